// File: rtl/cmp_arbiter.sv
// Round-robin arbiter sharing one registered WIDTH-bit compare unit between NUM_REQ requesters.
// One transaction in flight; the 4-bit flag result is returned on a valid/ready response channel.
module cmp_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int ID_W    = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [ID_W-1:0]            rsp_id,
  output logic [3:0]                 rsp_flag
);

  localparam int SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CMP  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]        state;
  logic [SEL_W-1:0]  rr_ptr;
  logic [SEL_W-1:0]  id_reg;
  logic [WIDTH-1:0]  a_reg;
  logic [WIDTH-1:0]  b_reg;

  logic [WIDTH-1:0]  a_arr [NUM_REQ];
  logic [WIDTH-1:0]  b_arr [NUM_REQ];

  logic [NUM_REQ-1:0] grant;
  logic [SEL_W-1:0]   sel;
  logic [SEL_W:0]     cand;
  logic               found;
  logic               accept;

  logic [WIDTH:0]     diff;
  logic               n_bit;
  logic               v_bit;
  logic [3:0]         flag;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign a_arr[gi] = req_a[gi*WIDTH +: WIDTH];
      assign b_arr[gi] = req_b[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Circular search starting at rr_ptr; the first valid requester wins.
  always_comb begin
    grant = '0;
    sel   = '0;
    found = 1'b0;
    cand  = '0;
    if (state == IDLE && !rst) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cand = {1'b0, rr_ptr} + (SEL_W+1)'(k);
        if (cand >= (SEL_W+1)'(NUM_REQ)) begin
          cand = cand - (SEL_W+1)'(NUM_REQ);
        end
        if (!found && req_valid[cand[SEL_W-1:0]]) begin
          found = 1'b1;
          sel   = cand[SEL_W-1:0];
          grant[cand[SEL_W-1:0]] = 1'b1;
        end
      end
    end
  end

  assign req_ready = grant;
  assign accept    = found;

  // Unsigned subtract with one extra bit so the MSB is the borrow.
  assign diff  = {1'b0, a_reg} - {1'b0, b_reg};
  assign n_bit = diff[WIDTH-1];
  assign v_bit = (a_reg[WIDTH-1] != b_reg[WIDTH-1]) && (diff[WIDTH-1] != a_reg[WIDTH-1]);
  assign flag  = {n_bit ^ v_bit, (diff[WIDTH-1:0] == '0), diff[WIDTH], v_bit};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      id_reg    <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_flag  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_reg  <= a_arr[sel];
            b_reg  <= b_arr[sel];
            id_reg <= sel;
            rr_ptr <= (sel == SEL_W'(NUM_REQ-1)) ? '0 : sel + 1'b1;
            state  <= CMP;
          end
        end
        CMP: begin
          rsp_flag  <= flag;
          rsp_id    <= ID_W'(id_reg);
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/cmp_arbiter.md
Name: cmp_arbiter

Overview:
Shares one 32-bit compare unit between NUM_REQ requesters, such as the branch unit, the set-less-than path and the trap-check logic. A round-robin arbiter grants one requester at a time and latches its operands. The compare is done in a registered cycle, and the 4-bit flag is returned on a single response channel with valid/ready backpressure. One transaction is in flight at a time.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
WIDTH, 32, operand width in bits
ID_W, 2, width of rsp_id; must satisfy 2^ID_W >= NUM_REQ

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester grant/accept, at most one bit high
req_a  in  NUM_REQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH]
req_b  in  NUM_REQ*WIDTH  operand B, same packing as req_a
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumer ready
rsp_id  out  ID_W  index of the requester owning the response
rsp_flag  out  4  compare result flags

Behaviour:
- Reset values (async, active-high): state=IDLE, rr_ptr=0, rsp_valid=0, rsp_id=0, rsp_flag=0, operand registers=0. req_ready is forced to 0 while rst is high.
- State machine has three states: IDLE, CMP, RESP.
- IDLE grant selection:
  - req_ready is combinational; only the granted index is high.
  - Grant goes to the first index with req_valid=1, searching circularly from rr_ptr (rr_ptr, rr_ptr+1, ... mod NUM_REQ).
  - If no req_valid is high, req_ready=0 and the block stays in IDLE.
- Accept: on a clock edge with req_valid[i] && req_ready[i]:
  - latch req_a[i], req_b[i] and id=i;
  - set rr_ptr = (i+1) mod NUM_REQ;
  - go to CMP.
  - rr_ptr changes only on an accept.
- CMP state, one cycle:
  - compute d = {1'b0,A} - {1'b0,B}, WIDTH+1 bits;
  - register rsp_flag and rsp_id; set rsp_valid=1; go to RESP.
  - req_ready=0 for all requesters.
- Flag encoding:
  - flag[3] = signed A<B, i.e. N xor V, where N=d[WIDTH-1].
  - flag[2] = A==B (d[WIDTH-1:0]==0).
  - flag[1] = unsigned A<B (borrow = d[WIDTH]).
  - flag[0] = signed overflow V = (A[msb]!=B[msb]) && (d[WIDTH-1]!=A[msb]).
  - A>B gives 4'b0000.
- RESP state:
  - rsp_valid, rsp_id and rsp_flag are held stable until rsp_valid && rsp_ready at a clock edge.
  - On that handshake: rsp_valid=0 and the state returns to IDLE. rsp_flag and rsp_id keep their last value.
  - req_ready=0 for all requesters while in RESP.
- Latency: accept at edge T, rsp_valid high after edge T+1. With rsp_ready tied high, the next accept is at edge T+3 at the earliest. Throughput is one compare per 3 cycles.
- Requesters must hold req_valid and operands stable until accepted. A requester that drops req_valid before grant is simply skipped.
- Simultaneous requests: only the round-robin winner is accepted. Losers see req_ready=0 and keep waiting. No requester starves; worst-case wait is NUM_REQ-1 transactions.
- Reset mid-operation (CMP or RESP): the transaction is discarded, no response is produced, and all registers return to reset values.
- Operands from a non-granted requester never affect rsp_flag.

Test Plan:
1. Requester 0 only, A=5, B=7 -> req_ready[0]=1 at the accept edge; rsp_valid after 2 edges; rsp_id=0, rsp_flag=4'b1010.
2. Requester 2 runs four compares:
   - A=B=0x00001234 -> 4'b0100
   - A=7, B=5 -> 4'b0000
   - A=0xFFFFFFFF, B=1 -> 4'b1000
   - A=0x80000000, B=1 -> 4'b1001 (signed overflow)
3. All four requesters hold req_valid from reset release, rsp_ready=1 -> grants and rsp_id occur in order 0,1,2,3,0. There are 3 cycles between accepts, and each requester's own flag is returned.
4. Backpressure: rsp_ready=0 for 5 cycles after rsp_valid rises -> rsp_valid, rsp_id and rsp_flag stay constant, and req_ready stays 0 for all requesters despite pending req_valid. Raising rsp_ready completes the handshake and the next grant follows.
5. rr_ptr=2 with requesters 0 and 3 valid -> requester 3 is granted first, then requester 0.
6. rst asserted asynchronously during CMP -> rsp_valid=0 immediately and never rises for that transaction. After release, the first grant goes to the lowest valid index, starting from 0.
